// File: rtl/rx_frame_reader_pkg.sv
`default_nettype none
// ============================================================================
// rx_frame_reader_pkg : rx event codes, reader state encodings, helpers
// Revision: 1.0
// ============================================================================
package rx_frame_reader_pkg;

  localparam logic [2:0] RX_EVENT_NONE = 3'd0;
  localparam logic [2:0] RX_EVENT_PHR  = 3'd1;
  localparam logic [2:0] RX_EVENT_END  = 3'd2;

  // reader section
  localparam int unsigned RFR_ST_W    = 2;
  localparam logic [1:0]  RFR_ST_IDLE = 2'd0;
  localparam logic [1:0]  RFR_ST_WAIT = 2'd1;
  localparam logic [1:0]  RFR_ST_OUT  = 2'd2;

  localparam int unsigned RFR_LEN_W   = 7;

  function automatic logic [RFR_LEN_W-1:0] rfr_len(input logic [7:0] len_byte);
    return len_byte[RFR_LEN_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_frame_reader_if.sv
`default_nettype none
// ============================================================================
// rx_frame_reader_if : payload byte stream, valid/ready with frame markers
// Revision: 1.0
// ============================================================================
interface rx_frame_reader_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       sof;
  logic       eof;

  modport master (output data, output valid, output sof, output eof, input ready);
  modport slave  (input data, input valid, input sof, input eof, output ready);
endinterface
`default_nettype wire

// File: rtl/rx_frame_reader_sat_counter.sv
`default_nettype none
// ============================================================================
// rx_frame_reader_sat_counter : W-bit up counter that sticks at all-ones
// Revision: 1.0
// ============================================================================
module rx_frame_reader_sat_counter #(
  parameter int W = 16
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         i_inc,
  output logic [W-1:0]      o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/rx_frame_reader.sv
`default_nettype none
// ============================================================================
// rx_frame_reader : reads a finished frame out of the rx buffer and streams it
// Revision: 1.0
// ============================================================================
module rx_frame_reader
  import rx_frame_reader_pkg::*;
#(
  parameter int ADDR_W  = 7,
  parameter int MAX_LEN = 127,
  parameter int CNT_W   = 16
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic [2:0]        i_ev,
  input  wire logic              i_ev_sig,
  output logic [ADDR_W-1:0]      o_buf_r_addr,
  input  wire logic [7:0]        i_buf_r_byte,
  rx_frame_reader_if.master      stream,
  output logic                   o_err,
  output logic                   o_busy,
  output logic [CNT_W-1:0]       o_frame_cnt,
  output logic [CNT_W-1:0]       o_drop_cnt
);

  localparam logic [RFR_LEN_W-1:0] C_MAX_LEN = RFR_LEN_W'(MAX_LEN);

  logic [RFR_ST_W-1:0]  r_state;
  logic [RFR_ST_W-1:0]  w_state_nxt;
  logic [RFR_LEN_W-1:0] r_k;
  logic [RFR_LEN_W-1:0] r_len;
  logic [ADDR_W-1:0]    r_addr;
  logic [7:0]           r_data;
  logic                 r_valid;
  logic                 r_sof;
  logic                 r_eof;
  logic                 r_err;
  logic                 r_abort;

  logic                 w_end;
  logic                 w_phr;
  logic [RFR_LEN_W-1:0] w_len;
  logic [RFR_LEN_W-1:0] w_k_inc;
  logic                 w_hs;
  logic                 w_last;
  logic                 w_abort;
  logic                 w_start;
  logic                 w_load;
  logic                 w_adv;
  logic                 w_frame_inc;
  logic                 w_drop;

  assign w_end   = i_ev_sig && (i_ev == RX_EVENT_END);
  assign w_phr   = i_ev_sig && (i_ev == RX_EVENT_PHR);
  assign w_len   = rfr_len(i_buf_r_byte);
  assign w_k_inc = r_k + 1'b1;
  assign w_hs    = r_valid && stream.ready;
  assign w_last  = (r_k == r_len);
  // An abort seen earlier in OUT, or arriving on the handshake cycle itself
  assign w_abort = r_abort || w_phr;
  assign w_start = (r_state == RFR_ST_IDLE) && w_end &&
                   (w_len != '0) && (w_len <= C_MAX_LEN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RFR_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RFR_ST_IDLE: if (w_start) w_state_nxt = RFR_ST_WAIT;
      RFR_ST_WAIT: w_state_nxt = w_phr ? RFR_ST_IDLE : RFR_ST_OUT;
      RFR_ST_OUT: begin
        if (w_hs) begin
          w_state_nxt = (w_last || w_abort) ? RFR_ST_IDLE : RFR_ST_WAIT;
        end
      end
      default: w_state_nxt = RFR_ST_IDLE;
    endcase
  end

  always_comb begin
    w_load      = 1'b0;
    w_adv       = 1'b0;
    w_frame_inc = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      RFR_ST_IDLE: begin
        if (w_end) begin
          if (w_len == '0)           w_frame_inc = 1'b1;
          else if (w_len > C_MAX_LEN) w_drop     = 1'b1;
        end
      end
      RFR_ST_WAIT: begin
        if (w_phr) w_drop = 1'b1;
        else       w_load = 1'b1;
      end
      RFR_ST_OUT: begin
        if (w_hs) begin
          if (w_last)       w_frame_inc = 1'b1;
          else if (w_abort) w_drop      = 1'b1;
          else              w_adv       = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_k     <= '0;
      r_len   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
      r_err   <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_err   <= w_drop;
      r_abort <= ((r_state == RFR_ST_OUT) && !w_hs) ? w_abort : 1'b0;
      if (w_start) begin
        r_k    <= RFR_LEN_W'(1);
        r_len  <= w_len;
        r_addr <= ADDR_W'(1);
      end
      if (w_load) begin
        r_data  <= i_buf_r_byte;
        r_valid <= 1'b1;
        r_sof   <= (r_k == RFR_LEN_W'(1));
        r_eof   <= w_last;
      end
      if (w_hs) begin
        r_valid <= 1'b0;
      end
      if (w_adv) begin
        r_k    <= w_k_inc;
        r_addr <= ADDR_W'(w_k_inc);
      end else if ((r_state != RFR_ST_IDLE) && (w_state_nxt == RFR_ST_IDLE)) begin
        r_addr <= '0;
      end
    end
  end

  rx_frame_reader_sat_counter #(.W(CNT_W)) u_frame_cnt (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_frame_inc),
    .o_cnt (o_frame_cnt)
  );

  rx_frame_reader_sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_drop),
    .o_cnt (o_drop_cnt)
  );

  assign o_buf_r_addr = r_addr;
  assign stream.data  = r_data;
  assign stream.valid = r_valid;
  assign stream.sof   = r_sof;
  assign stream.eof   = r_eof;
  assign o_err        = r_err;
  assign o_busy       = (r_state != RFR_ST_IDLE);

endmodule
`default_nettype wire
